fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_1000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the encoding driven on ir while valid_out=0.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 stall_in  input  1  decode cannot accept a new instruction; hold ir/pc_out/valid_out.
REQ-007 branch_taken  input  1  redirect fetch; flush the in-flight instruction.
REQ-008 branch_target  input  32  redirect address; bits [1:0] ignored and treated as 00.
REQ-009 imem_req  output  1  instruction fetch request to the cache/MMU.
REQ-010 imem_addr  output  32  fetch address, word-aligned.
REQ-011 imem_ready  input  1  imem_data valid this cycle; completes the request.
REQ-012 imem_data  input  32  instruction word returned.
REQ-013 ir  output  32  registered instruction to decode.
REQ-014 pc_out  output  32  registered PC of ir.
REQ-015 valid_out  output  1  ir/pc_out hold a real instruction; 0 = bubble.

Function
REQ-016 SHALL hold internal pc (32 bits); imem_addr = pc whenever imem_req=1.
REQ-017 SHALL implement states REQ, HOLD, DROP.
REQ-018 REQ: imem_req=1. imem_addr SHALL stay stable until imem_ready=1.
REQ-019 REQ, imem_ready=1, stall_in=0, branch_taken=0: next edge loads ir<=imem_data, pc_out<=pc, valid_out<=1, pc<=pc+4; state stays REQ. Throughput is 1 instruction/cycle on back-to-back hits.
REQ-020 REQ, imem_ready=0, stall_in=0, branch_taken=0: next edge sets valid_out<=0 and ir<=NOP_INSTR; pc is unchanged.
REQ-021 stall_in=1, branch_taken=0: ir, pc_out and valid_out SHALL hold.
  - If imem_ready=1 in REQ, capture imem_data and pc into a one-entry skid buffer, set pc<=pc+4, go to HOLD.
REQ-022 HOLD: imem_req=0.
  - When stall_in=0: next edge loads ir/pc_out from the skid buffer, sets valid_out<=1, and returns to REQ.
REQ-023 branch_taken SHALL have priority over stall_in and imem_ready. Next edge:
  - valid_out<=0, ir<=NOP_INSTR;
  - skid buffer invalidated;
  - pc<={branch_target[31:2],2'b00}.
REQ-024 branch_taken in REQ with imem_ready=1: discard imem_data and stay in REQ; the next request goes to the target.
REQ-025 branch_taken in REQ with imem_ready=0: go to DROP.
  - DROP keeps imem_req=1 with the old address stable.
  - On imem_ready=1, discard the data and go to REQ at the target.
REQ-026 A branch_taken arriving in DROP SHALL overwrite the pending target; the state stays DROP.
REQ-027 A branch_taken arriving in HOLD SHALL go to REQ at the target.
REQ-028 pc increment SHALL wrap modulo 2^32: 32'hFFFF_FFFC+4 = 0.
REQ-029 Outputs SHALL be registered only; no combinational path from imem_data to ir.

Reset
REQ-030 reset=0 SHALL asynchronously set:
  - pc=RESET_PC, state=REQ;
  - valid_out=0, ir=NOP_INSTR, pc_out=0;
  - skid buffer invalid.
REQ-031 imem_req SHALL be 0 while reset=0.
  - It rises in the first cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-032 A reset asserted mid-request SHALL abandon the request; no data returned afterwards is used.

Structure
REQ-033 State encoding (REQ/HOLD/DROP) and the NOP_INSTR default SHALL live in the shared CPU package alongside the ALU opcode constants.
REQ-034 The one-entry skid buffer MAY be a sub-module fetch_skid_buf.
  - Ports: data+pc in, load, clear, valid out.
  - Otherwise a single module.

Verification
REQ-035 Reset release, imem_ready=1 every cycle, stall_in=0:
  - imem_addr sequence 0x1000, 0x1004, 0x1008;
  - ir appears one cycle after each ready, valid_out=1 continuously.
REQ-036 imem_ready low for 3 cycles at 0x1004:
  - imem_addr held at 0x1004;
  - valid_out=0 with ir=NOP_INSTR for 3 cycles, then pc_out=0x1004, valid_out=1.
REQ-037 stall_in high 4 cycles while 0x1008 returns:
  - outputs frozen on 0x1004, imem_req drops, HOLD entered;
  - after stall release, pc_out=0x1008, valid_out=1, next fetch 0x100C.
REQ-038 branch_taken with target 0x2003 during an outstanding miss at 0x100C:
  - imem_addr stays 0x100C until ready and that data is discarded;
  - next imem_addr=0x2000; no valid_out for 0x100C.
REQ-039 branch_taken and stall_in together, skid buffer full:
  - valid_out=0 next cycle, skid buffer cleared, next fetch at target.
REQ-040 pc=0xFFFF_FFFC fetched with imem_ready=1:
  - next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU package: fetch FSM encoding, fetch defaults, ALU opcodes.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  // Fetch FSM states: issuing requests, parked on a stalled word, or
  // waiting out a request whose data will be thrown away.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_1000;

  // ALU opcode constants used by the execute stage.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and the cache/MMU.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] data_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid
);

  logic [XLEN-1:0] data_reg;
  logic [XLEN-1:0] pc_reg;
  logic            valid_reg;

  // Capture on load; clear wins so a flush never leaves a stale entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg  <= '0;
      pc_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= data_in;
      pc_reg    <= pc_in;
      valid_reg <= 1'b1;
    end
  end

  assign data_out = data_reg;
  assign pc_out   = pc_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, stall skid buffer, branch redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_in,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    branch_target,
  fetch_stage_if.master      imem,
  output logic [XLEN-1:0]    ir,
  output logic [XLEN-1:0]    pc_out,
  output logic               valid_out
);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] target_reg, target_next;
  logic [XLEN-1:0] ir_reg, ir_next;
  logic [XLEN-1:0] pc_out_reg, pc_out_next;
  logic            valid_reg, valid_next;

  logic            skid_load, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_data, skid_pc;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .clear    (skid_clear),
    .data_in  (imem.imem_data),
    .pc_in    (pc_reg),
    .data_out (skid_data),
    .pc_out   (skid_pc),
    .valid    (skid_valid)
  );

  // No request while in reset or while parked on a stalled word.
  assign imem.imem_req  = reset && (state_reg != ST_HOLD);
  assign imem.imem_addr = pc_reg;

  assign ir        = ir_reg;
  assign pc_out    = pc_out_reg;
  assign valid_out = valid_reg;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_REQ;
      pc_reg     <= RESET_PC;
      target_reg <= '0;
      ir_reg     <= NOP_INSTR;
      pc_out_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      ir_reg     <= ir_next;
      pc_out_reg <= pc_out_next;
      valid_reg  <= valid_next;
    end
  end

  // Next-state and datapath control; branch beats stall and imem_ready.
  // In DROP the pc stays on the abandoned address so imem_addr is stable,
  // and the redirect target waits in target_reg until the request retires.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    ir_next     = ir_reg;
    pc_out_next = pc_out_reg;
    valid_next  = valid_reg;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;

    if (branch_taken) begin
      ir_next    = NOP_INSTR;
      valid_next = 1'b0;
      skid_clear = 1'b1;
    end

    case (state_reg)
      ST_REQ: begin
        if (branch_taken) begin
          if (imem.imem_ready) begin
            pc_next = word_align(branch_target);
          end else begin
            target_next = word_align(branch_target);
            state_next  = ST_DROP;
          end
        end else if (stall_in) begin
          if (imem.imem_ready) begin
            skid_load  = 1'b1;
            pc_next    = pc_reg + 32'd4;
            state_next = ST_HOLD;
          end
        end else if (imem.imem_ready) begin
          ir_next     = imem.imem_data;
          pc_out_next = pc_reg;
          valid_next  = 1'b1;
          pc_next     = pc_reg + 32'd4;
        end else begin
          ir_next    = NOP_INSTR;
          valid_next = 1'b0;
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          pc_next    = word_align(branch_target);
          state_next = ST_REQ;
        end else if (!stall_in && skid_valid) begin
          ir_next     = skid_data;
          pc_out_next = skid_pc;
          valid_next  = 1'b1;
          skid_clear  = 1'b1;
          state_next  = ST_REQ;
        end
      end
      ST_DROP: begin
        if (!stall_in) begin
          ir_next    = NOP_INSTR;
          valid_next = 1'b0;
        end
        if (imem.imem_ready) begin
          pc_next    = branch_taken ? word_align(branch_target) : target_reg;
          state_next = ST_REQ;
        end else if (branch_taken) begin
          target_next = word_align(branch_target);
        end
      end
      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

endmodule
